// File: rtl/hazard_pkg.sv
// Shared types and width helpers for the hazard/forwarding controller.
// Scoreboard entries carry rd at a fixed maximum width.
package hazard_pkg;

  localparam int FWD_RF    = 0;
  localparam int REG_W_MAX = 8;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] rd;
    logic                 wen;
    logic                 is_load;
  } sb_entry_t;

  function automatic int sel_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side request and control-response bundle of hazard_ctrl.
// Widths follow the same helpers the controller uses internally.
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int DEPTH = 3
);

  localparam int SEL_W = sel_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_wen;
  logic             id_is_load;
  logic             id_is_store;
  logic             redirect;
  logic             stall;
  logic             flush;
  logic             issue;
  logic [SEL_W-1:0] fwd_a_sel;
  logic [SEL_W-1:0] fwd_b_sel;
  logic [CNT_W-1:0] inflight;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_use_rs1, id_use_rs2,
    output id_rd, id_wen, id_is_load,
    output id_is_store, redirect,
    input  stall, flush, issue,
    input  fwd_a_sel, fwd_b_sel, inflight
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_use_rs1, id_use_rs2,
    input  id_rd, id_wen, id_is_load,
    input  id_is_store, redirect,
    output stall, flush, issue,
    output fwd_a_sel, fwd_b_sel, inflight
  );

endinterface

// File: rtl/hazard_ctrl_inflight_pipe.sv
// Shift-register scoreboard of in-flight destinations, execute..writeback.
// Produces per-stage source match vectors and the writing-entry count.
module inflight_pipe
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  sb_entry_t        push_e,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use1,
  input  logic             use2,
  output logic [DEPTH:1]   m1,
  output logic [DEPTH:1]   m2,
  output logic [DEPTH:1]   ld,
  output logic [CNT_W-1:0] inflight
);

  sb_entry_t        sb  [1:DEPTH];
  sb_entry_t        nxt [1:DEPTH];
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    nxt[1] = push ? push_e : '0;
    for (int s = 2; s <= DEPTH; s++)
      nxt[s] = sb[s-1];
    cnt_nxt = '0;
    for (int s = 1; s <= DEPTH; s++)
      if (nxt[s].valid && nxt[s].wen)
        cnt_nxt = cnt_nxt + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 1; s <= DEPTH; s++)
        sb[s] <= '0;
      inflight <= '0;
    end else begin
      for (int s = 1; s <= DEPTH; s++)
        sb[s] <= nxt[s];
      inflight <= cnt_nxt;
    end
  end

  // x0 never creates a dependency
  always_comb begin
    m1 = '0;
    m2 = '0;
    ld = '0;
    for (int s = 1; s <= DEPTH; s++) begin
      ld[s] = sb[s].is_load;
      m1[s] = sb[s].valid & sb[s].wen & use1
            & (rs1 != '0)
            & (sb[s].rd == REG_W_MAX'(rs1));
      m2[s] = sb[s].valid & sb[s].wen & use2
            & (rs2 != '0)
            & (sb[s].rd == REG_W_MAX'(rs2));
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall, flush and registered forwarding-select control for the
// instruction leaving decode, over a DEPTH-stage in-flight scoreboard.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int DEPTH        = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int RF_BYPASS    = 0
) (
  input logic         clock,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam int SEL_W  = sel_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam int FC_W   = cnt_w(FLUSH_CYCLES);
  localparam int LD_THR = 1 + LOAD_LAT;
  localparam int ST_THR = LOAD_LAT;

  typedef struct packed {
    logic             stall;
    logic [SEL_W-1:0] sel;
  } res_t;

  logic [DEPTH:1]   m1, m2, ld;
  logic [CNT_W-1:0] inflight_q;
  logic [FC_W-1:0]  flush_cnt;
  logic [SEL_W-1:0] fwd_a_q, fwd_b_q;
  sb_entry_t        push_e;
  res_t             ra, rb;
  logic             stall, flush, issue;

  // Walk oldest to youngest so the youngest match wins
  function automatic res_t resolve(
    input logic [DEPTH:1] m,
    input logic [DEPTH:1] l,
    input int             thr
  );
    res_t r;
    r = '0;
    for (int s = DEPTH; s >= 1; s--) begin
      if (m[s]) begin
        r = '0;
        if (l[s] && s < thr)
          r.stall = 1'b1;
        else if (s < DEPTH)
          r.sel = SEL_W'(s);
        else
          r.stall = (RF_BYPASS == 0);
      end
    end
    return r;
  endfunction

  assign push_e = '{
    valid:   1'b1,
    rd:      REG_W_MAX'(hz.id_rd),
    wen:     hz.id_wen,
    is_load: hz.id_is_load
  };

  inflight_pipe #(
    .REG_W (REG_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_pipe (
    .clock    (clock),
    .reset    (reset),
    .push     (issue),
    .push_e   (push_e),
    .rs1      (hz.id_rs1),
    .rs2      (hz.id_rs2),
    .use1     (hz.id_use_rs1),
    .use2     (hz.id_use_rs2),
    .m1       (m1),
    .m2       (m2),
    .ld       (ld),
    .inflight (inflight_q)
  );

  always_comb begin
    ra = resolve(m1, ld, LD_THR);
    rb = resolve(m2, ld,
                 hz.id_is_store ? ST_THR : LD_THR);
  end

  assign flush = hz.redirect | (flush_cnt != '0);
  assign stall = hz.id_valid & (ra.stall | rb.stall)
               & ~flush;
  assign issue = hz.id_valid & ~stall & ~flush & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      flush_cnt <= '0;
      fwd_a_q   <= '0;
      fwd_b_q   <= '0;
    end else begin
      if (hz.redirect)
        flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
      else if (flush_cnt != '0)
        flush_cnt <= flush_cnt - FC_W'(1);
      fwd_a_q <= issue ? ra.sel : SEL_W'(FWD_RF);
      fwd_b_q <= issue ? rb.sel : SEL_W'(FWD_RF);
    end
  end

  assign hz.stall     = stall;
  assign hz.flush     = flush;
  assign hz.issue     = issue;
  assign hz.fwd_a_sel = fwd_a_q;
  assign hz.fwd_b_sel = fwd_b_q;
  assign hz.inflight  = inflight_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (no bypass / bypass) share one
// decode stream; an age-based model feeds a queue checked by a monitor.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int REG_W        = 5;
  localparam int DEPTH        = 3;
  localparam int LOAD_LAT     = 1;
  localparam int FLUSH_CYCLES = 2;

  typedef struct {
    bit       v;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
    bit [4:0] rd;
    bit       wen;
    bit       ld;
    bit       st;
  } ins_t;

  typedef struct {
    int       d;
    int       c;
    bit [4:0] rd;
    bit       wen;
    bit       ld;
  } rec_t;

  typedef struct {
    bit    chk;
    string tag;
    bit    flush;
    bit    stall [2];
    bit    issue [2];
    int    fa    [2];
    int    fb    [2];
    int    inf   [2];
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_wen = 1'b0, id_is_load = 1'b0;
  logic       id_is_store = 1'b0, redirect = 1'b0;

  always #5 clock = ~clock;

  hazard_ctrl_if #(.REG_W(REG_W), .DEPTH(DEPTH)) h0 ();
  hazard_ctrl_if #(.REG_W(REG_W), .DEPTH(DEPTH)) h1 ();

  assign h0.id_valid    = id_valid;
  assign h0.id_rs1      = id_rs1;
  assign h0.id_rs2      = id_rs2;
  assign h0.id_use_rs1  = id_use_rs1;
  assign h0.id_use_rs2  = id_use_rs2;
  assign h0.id_rd       = id_rd;
  assign h0.id_wen      = id_wen;
  assign h0.id_is_load  = id_is_load;
  assign h0.id_is_store = id_is_store;
  assign h0.redirect    = redirect;
  assign h1.id_valid    = id_valid;
  assign h1.id_rs1      = id_rs1;
  assign h1.id_rs2      = id_rs2;
  assign h1.id_use_rs1  = id_use_rs1;
  assign h1.id_use_rs2  = id_use_rs2;
  assign h1.id_rd       = id_rd;
  assign h1.id_wen      = id_wen;
  assign h1.id_is_load  = id_is_load;
  assign h1.id_is_store = id_is_store;
  assign h1.redirect    = redirect;

  hazard_ctrl #(
    .REG_W(REG_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT),
    .FLUSH_CYCLES(FLUSH_CYCLES), .RF_BYPASS(0)
  ) dut0 (.clock(clock), .reset(reset), .hz(h0.slave));

  hazard_ctrl #(
    .REG_W(REG_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT),
    .FLUSH_CYCLES(FLUSH_CYCLES), .RF_BYPASS(1)
  ) dut1 (.clock(clock), .reset(reset), .hz(h1.slave));

  exp_t q [$];
  rec_t recs [$];
  int   cyc = 0;
  int   last_redir = -100;
  bit   reg_known = 0;
  int   nfa [2], nfb [2], ninf [2];
  int   n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%s] actual=%0d required=%0d",
               nm, tag, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("flush0", e.tag, 32'(h0.flush), 32'(e.flush));
      chk("flush1", e.tag, 32'(h1.flush), 32'(e.flush));
      chk("stall0", e.tag, 32'(h0.stall), 32'(e.stall[0]));
      chk("stall1", e.tag, 32'(h1.stall), 32'(e.stall[1]));
      chk("issue0", e.tag, 32'(h0.issue), 32'(e.issue[0]));
      chk("issue1", e.tag, 32'(h1.issue), 32'(e.issue[1]));
      if (e.chk) begin
        chk("fwd_a0", e.tag, 32'(h0.fwd_a_sel), e.fa[0]);
        chk("fwd_b0", e.tag, 32'(h0.fwd_b_sel), e.fb[0]);
        chk("infl0",  e.tag, 32'(h0.inflight),  e.inf[0]);
        chk("fwd_a1", e.tag, 32'(h1.fwd_a_sel), e.fa[1]);
        chk("fwd_b1", e.tag, 32'(h1.fwd_b_sel), e.fb[1]);
        chk("infl1",  e.tag, 32'(h1.inflight),  e.inf[1]);
      end
    end
  end

  // Producer age = cycles since it left decode; youngest matching one decides
  function automatic void src(input int d, input bit [4:0] r,
                              input bit u, input int thr,
                              output bit st, output int sel);
    int best;
    bit bl;
    best = 0;
    bl   = 0;
    st   = 0;
    sel  = 0;
    if (!u || r == 0) return;
    foreach (recs[k]) begin
      int age;
      age = cyc - recs[k].c;
      if (recs[k].d == d && recs[k].wen && recs[k].rd == r &&
          age >= 1 && age <= DEPTH && (best == 0 || age < best)) begin
        best = age;
        bl   = recs[k].ld;
      end
    end
    if (best == 0) return;
    if (bl && best < thr) st = 1;
    else if (best < DEPTH) sel = best;
    else st = (d == 0);
  endfunction

  task automatic cycle(input ins_t i, input bit redir,
                       input bit rst, input string tag,
                       output bit iss0);
    exp_t e;
    bit   fl, sa, sb;
    int   sela, selb, thb;
    id_valid    = i.v;
    id_rs1      = i.rs1;
    id_rs2      = i.rs2;
    id_use_rs1  = i.u1;
    id_use_rs2  = i.u2;
    id_rd       = i.rd;
    id_wen      = i.wen;
    id_is_load  = i.ld;
    id_is_store = i.st;
    redirect    = redir;
    reset       = rst;
    e.chk = reg_known;
    e.tag = tag;
    for (int d = 0; d < 2; d++) begin
      e.fa[d]  = nfa[d];
      e.fb[d]  = nfb[d];
      e.inf[d] = ninf[d];
    end
    fl = redir || (cyc > last_redir &&
                   cyc - last_redir < FLUSH_CYCLES);
    e.flush = fl;
    thb = i.st ? LOAD_LAT : 1 + LOAD_LAT;
    for (int d = 0; d < 2; d++) begin
      src(d, i.rs1, i.u1, 1 + LOAD_LAT, sa, sela);
      src(d, i.rs2, i.u2, thb, sb, selb);
      e.stall[d] = i.v && (sa || sb) && !fl;
      e.issue[d] = i.v && !e.stall[d] && !fl && !rst;
      nfa[d] = e.issue[d] ? sela : 0;
      nfb[d] = e.issue[d] ? selb : 0;
      if (e.issue[d])
        recs.push_back('{d: d, c: cyc, rd: i.rd,
                         wen: i.wen, ld: i.ld});
    end
    if (rst) begin
      recs.delete();
      last_redir = -100;
    end else if (redir) begin
      last_redir = cyc;
    end
    for (int k = recs.size() - 1; k >= 0; k--)
      if (cyc + 1 - recs[k].c > DEPTH) recs.delete(k);
    for (int d = 0; d < 2; d++) begin
      ninf[d] = 0;
      foreach (recs[k])
        if (recs[k].d == d && recs[k].wen) ninf[d]++;
    end
    q.push_back(e);
    reg_known = 1;
    iss0 = e.issue[0];
    @(posedge clock);
    cyc++;
    #1;
  endtask

  function automatic ins_t mk(input bit [4:0] rd, input bit wen,
                              input bit [4:0] rs1, input bit u1,
                              input bit [4:0] rs2, input bit u2,
                              input bit ld, input bit st);
    ins_t i;
    i = '{v: 1, rs1: rs1, rs2: rs2, u1: u1, u2: u2,
          rd: rd, wen: wen, ld: ld, st: st};
    return i;
  endfunction

  function automatic ins_t rnd();
    ins_t i;
    i.v   = ($urandom_range(0, 3) != 0);
    i.rs1 = 5'($urandom_range(0, 7));
    i.rs2 = 5'($urandom_range(0, 7));
    i.u1  = ($urandom_range(0, 3) != 0);
    i.u2  = ($urandom_range(0, 1) != 0);
    i.rd  = 5'($urandom_range(0, 7));
    i.wen = ($urandom_range(0, 3) != 0);
    i.ld  = ($urandom_range(0, 2) == 0);
    i.st  = !i.ld && ($urandom_range(0, 3) == 0);
    return i;
  endfunction

  task automatic send(input ins_t i, input string tag);
    bit ok;
    for (int n = 0; n < 8; n++) begin
      cycle(i, 0, 0, tag, ok);
      if (ok) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send [%s] issue=0 required=1", tag);
  endtask

  task automatic idle(input int n);
    ins_t i;
    bit   ok;
    i = '{default: 0};
    for (int k = 0; k < n; k++) cycle(i, 0, 0, "idle", ok);
  endtask

  initial begin
    ins_t idl, lw6, c, cur;
    bit   ok, rd_, rs_;
    idl = '{default: 0};
    @(posedge clock);
    #1;
    cycle(idl, 0, 1, "reset", ok);
    cycle(idl, 0, 1, "reset", ok);
    idle(2);

    send(mk(5, 1, 1, 1, 2, 1, 0, 0), "prod_x5");
    send(mk(8, 1, 5, 1, 3, 1, 0, 0), "use_x5");
    idle(3);

    lw6 = mk(6, 1, 1, 1, 0, 0, 1, 0);
    send(lw6, "lw_x6");
    send(mk(9, 1, 4, 1, 6, 1, 0, 0), "ld_use_b");
    idle(3);
    send(lw6, "lw_x6");
    send(mk(0, 0, 2, 1, 6, 1, 0, 1), "sw_data");
    idle(3);
    send(lw6, "lw_x6");
    send(mk(0, 0, 6, 1, 3, 1, 0, 1), "sw_addr");
    idle(3);

    send(mk(7, 1, 1, 1, 2, 1, 0, 0), "prod_x7");
    send(mk(10, 1, 1, 1, 2, 1, 0, 0), "gap1");
    send(mk(11, 1, 2, 1, 3, 1, 0, 0), "gap2");
    send(mk(12, 1, 7, 1, 3, 1, 0, 0), "use_x7_wb");
    idle(3);

    c = mk(13, 1, 1, 1, 2, 1, 0, 0);
    cycle(c, 1, 0, "redir1", ok);
    cycle(c, 0, 0, "flush1", ok);
    send(c, "after_flush");
    cycle(c, 1, 0, "redir2a", ok);
    cycle(c, 1, 0, "redir2b", ok);
    cycle(c, 0, 0, "flush_ext", ok);
    send(c, "after_ext");
    idle(2);
    send(lw6, "lw_x6");
    c = mk(14, 1, 6, 1, 6, 1, 0, 0);
    cycle(c, 1, 0, "flush_haz", ok);
    cycle(c, 0, 0, "flush_haz2", ok);
    send(c, "haz_after");
    idle(3);

    send(mk(0, 1, 1, 1, 2, 1, 1, 0), "ld_x0");
    send(mk(15, 1, 0, 1, 0, 1, 0, 0), "use_x0");
    send(lw6, "lw_x6");
    send(mk(16, 1, 1, 1, 6, 0, 0, 0), "rs2_unused");
    idle(3);

    send(lw6, "lw_x6");
    c = mk(17, 1, 6, 1, 2, 1, 0, 0);
    cycle(c, 0, 0, "stall_pre_rst", ok);
    cycle(c, 0, 1, "rst_in_stall", ok);
    send(c, "after_rst");
    idle(2);
    cycle(c, 1, 0, "redir_pre_rst", ok);
    cycle(c, 0, 1, "rst_in_flush", ok);
    send(c, "after_rst2");
    idle(2);

    cur = rnd();
    repeat (500) begin
      rs_ = ($urandom_range(0, 59) == 0);
      rd_ = !rs_ && ($urandom_range(0, 9) == 0);
      cycle(cur, rd_, rs_, "rand", ok);
      if (ok || rs_ || !cur.v) cur = rnd();
    end
    idle(2);

    for (int k = 0; k < 5 && q.size() > 0; k++)
      @(posedge clock);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
